// File: rtl/alarm_clock_if.sv
// Control inputs and display outputs of the alarm clock, bundled for the
// bench (master) and the clock itself (slave).
interface alarm_clock_if;
   logic       i_run;
   logic [1:0] i_sel;
   logic       i_tgt;
   logic       i_plus;
   logic       i_minus;
   logic       i_alarm_en;
   logic       i_alarm_ack;
   logic [4:0] o_hours;
   logic [5:0] o_mins;
   logic [5:0] o_secs;
   logic [2:0] o_blank;
   logic       o_ring;
   logic       o_tick_1hz;

   modport master (
      output i_run, i_sel, i_tgt, i_plus, i_minus, i_alarm_en, i_alarm_ack,
      input  o_hours, o_mins, o_secs, o_blank, o_ring, o_tick_1hz
   );

   modport slave (
      input  i_run, i_sel, i_tgt, i_plus, i_minus, i_alarm_en, i_alarm_ack,
      output o_hours, o_mins, o_secs, o_blank, o_ring, o_tick_1hz
   );
endinterface

// File: rtl/alarm_clock.sv
// 24h time-of-day clock with an hours:mins alarm, per-field editing,
// a timed ring state machine and flash blanking of edited/ringing fields.
module alarm_clock #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int FRE       = 2,
   parameter int DC        = 80,
   parameter int RING_SECS = 60
) (
   input  logic         i_clk,
   input  logic         i_reset,
   alarm_clock_if.slave bus
);
   localparam int FLASH_P = CLK_FREQ / FRE;
   localparam int PW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int FW      = (FLASH_P > 1) ? $clog2(FLASH_P) : 1;
   localparam int RW      = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
   localparam longint FLASH_ON_L = (longint'(FLASH_P) * longint'(DC)) / 64'sd100;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
   localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_P - 1);
   localparam logic [FW-1:0] FLASH_ON  = FW'(FLASH_ON_L);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RINGING = 1'b1} state_t;

   function automatic logic [5:0] f_step60(input logic [5:0] val, input logic up);
      logic [5:0] res;
      if (up) res = (val == 6'd59) ? 6'd0 : val + 6'd1;
      else    res = (val == 6'd0) ? 6'd59 : val - 6'd1;
      return res;
   endfunction

   function automatic logic [4:0] f_step24(input logic [4:0] val, input logic up);
      logic [4:0] res;
      if (up) res = (val == 5'd23) ? 5'd0 : val + 5'd1;
      else    res = (val == 5'd0) ? 5'd23 : val - 5'd1;
      return res;
   endfunction

   state_t        r_state, w_state_nx;
   logic [4:0]    r_hour, r_alm_hour, w_hour_nx, w_alm_hour_nx;
   logic [5:0]    r_min, r_sec, r_alm_min, w_min_nx, w_sec_nx, w_alm_min_nx;
   logic [PW-1:0] r_presc, w_presc_nx;
   logic [FW-1:0] r_flash, w_flash_nx;
   logic [RW-1:0] r_ring_cnt, w_ring_cnt_nx;
   logic [2:0]    r_blank, w_blank_nx;
   logic          r_tick;
   logic          w_count_en, w_tick, w_edit, w_edit_time, w_edit_alarm;
   logic          w_match, w_ring_timeout, w_flash_en, w_ring;

   assign w_count_en     = bus.i_run && (bus.i_sel == 2'b00);
   assign w_tick         = w_count_en && (r_presc == PRESC_MAX);
   assign w_edit         = (bus.i_sel != 2'b00) && (bus.i_plus ^ bus.i_minus);
   assign w_edit_time    = w_edit && !bus.i_tgt;
   assign w_edit_alarm   = w_edit && bus.i_tgt;
   assign w_ring_timeout = w_tick && (r_ring_cnt == RING_LAST);
   // Only a counting tick can raise a match, so edits onto the alarm time stay silent.
   assign w_match        = w_tick && bus.i_alarm_en && (w_sec_nx == 6'd0) &&
                           (w_min_nx == r_alm_min) && (w_hour_nx == r_alm_hour);

   // Next time of day: a tick carries through all fields, an edit touches one field.
   always_comb begin
      w_sec_nx  = r_sec;
      w_min_nx  = r_min;
      w_hour_nx = r_hour;
      if (w_tick) begin
         w_sec_nx = f_step60(r_sec, 1'b1);
         if (r_sec == 6'd59) begin
            w_min_nx = f_step60(r_min, 1'b1);
            if (r_min == 6'd59) begin
               w_hour_nx = f_step24(r_hour, 1'b1);
            end else begin
               w_hour_nx = r_hour;
            end
         end else begin
            w_min_nx = r_min;
         end
      end else if (w_edit_time) begin
         case (bus.i_sel)
            2'b01:   w_sec_nx  = f_step60(r_sec, bus.i_plus);
            2'b10:   w_min_nx  = f_step60(r_min, bus.i_plus);
            2'b11:   w_hour_nx = f_step24(r_hour, bus.i_plus);
            default: w_sec_nx  = r_sec;
         endcase
      end else begin
         w_sec_nx = r_sec;
      end
   end

   // Next alarm setting and prescaler value.
   always_comb begin
      w_alm_min_nx  = r_alm_min;
      w_alm_hour_nx = r_alm_hour;
      w_presc_nx    = r_presc;
      if (w_edit_alarm) begin
         case (bus.i_sel)
            2'b10:   w_alm_min_nx  = f_step60(r_alm_min, bus.i_plus);
            2'b11:   w_alm_hour_nx = f_step24(r_alm_hour, bus.i_plus);
            default: w_alm_min_nx  = r_alm_min;
         endcase
      end else begin
         w_alm_min_nx = r_alm_min;
      end
      if (w_edit_time) begin
         w_presc_nx = {PW{1'b0}};
      end else if (w_count_en) begin
         w_presc_nx = w_tick ? {PW{1'b0}} : r_presc + PW'(1);
      end else begin
         w_presc_nx = r_presc;
      end
   end

   // Ring FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nx;
   end

   // Ring FSM next state; acknowledge beats a coincident match.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_match && !bus.i_alarm_ack) w_state_nx = ST_RINGING;
            else                             w_state_nx = ST_IDLE;
         end
         ST_RINGING: begin
            if (bus.i_alarm_ack || !bus.i_alarm_en || w_ring_timeout) w_state_nx = ST_IDLE;
            else                                                      w_state_nx = ST_RINGING;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Ring FSM outputs.
   always_comb begin
      w_ring = 1'b0;
      case (r_state)
         ST_RINGING: w_ring = 1'b1;
         ST_IDLE:    w_ring = 1'b0;
         default:    w_ring = 1'b0;
      endcase
   end

   // Ring-duration counter, flash phase counter and the blank mask they drive.
   always_comb begin
      w_ring_cnt_nx = {RW{1'b0}};
      w_flash_nx    = {FW{1'b0}};
      w_blank_nx    = 3'b000;
      if ((r_state == ST_RINGING) && (w_state_nx == ST_RINGING)) begin
         w_ring_cnt_nx = w_tick ? r_ring_cnt + RW'(1) : r_ring_cnt;
      end else begin
         w_ring_cnt_nx = {RW{1'b0}};
      end
      w_flash_en = (bus.i_sel != 2'b00) || (r_state == ST_RINGING);
      if (!w_flash_en || (r_flash == FLASH_MAX)) begin
         w_flash_nx = {FW{1'b0}};
      end else begin
         w_flash_nx = r_flash + FW'(1);
      end
      // Mode follows the next state so blanking drops on the same edge ringing ends.
      if (r_flash < FLASH_ON) begin
         w_blank_nx = 3'b000;
      end else if (bus.i_sel != 2'b00) begin
         case (bus.i_sel)
            2'b01:   w_blank_nx = 3'b001;
            2'b10:   w_blank_nx = 3'b010;
            2'b11:   w_blank_nx = 3'b100;
            default: w_blank_nx = 3'b000;
         endcase
      end else if (w_state_nx == ST_RINGING) begin
         w_blank_nx = 3'b111;
      end else begin
         w_blank_nx = 3'b000;
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sec      <= 6'd0;
         r_min      <= 6'd0;
         r_hour     <= 5'd0;
         r_alm_min  <= 6'd0;
         r_alm_hour <= 5'd0;
         r_presc    <= {PW{1'b0}};
         r_flash    <= {FW{1'b0}};
         r_ring_cnt <= {RW{1'b0}};
         r_blank    <= 3'b000;
         r_tick     <= 1'b0;
      end else begin
         r_sec      <= w_sec_nx;
         r_min      <= w_min_nx;
         r_hour     <= w_hour_nx;
         r_alm_min  <= w_alm_min_nx;
         r_alm_hour <= w_alm_hour_nx;
         r_presc    <= w_presc_nx;
         r_flash    <= w_flash_nx;
         r_ring_cnt <= w_ring_cnt_nx;
         r_blank    <= w_blank_nx;
         r_tick     <= w_tick;
      end
   end

   assign bus.o_hours    = bus.i_tgt ? r_alm_hour : r_hour;
   assign bus.o_mins     = bus.i_tgt ? r_alm_min  : r_min;
   assign bus.o_secs     = bus.i_tgt ? 6'd0       : r_sec;
   assign bus.o_blank    = r_blank;
   assign bus.o_ring     = w_ring;
   assign bus.o_tick_1hz = r_tick;
endmodule

// File: tb/tb_alarm_clock.sv
// Scenario bench for alarm_clock: expectations are queued as stimulus is
// applied and popped for comparison once the clock edge has produced them.
module tb_alarm_clock;
   localparam logic [21:0] M_TIME  = 22'h3FFFE0;
   localparam logic [21:0] M_BLANK = 22'h00001C;
   localparam logic [21:0] M_RING  = 22'h000002;
   localparam logic [21:0] M_TICK  = 22'h000001;
   localparam logic [21:0] M_ALL   = 22'h3FFFFF;

   typedef struct {
      string       tag;
      logic [21:0] val;
      logic [21:0] mask;
   } exp_t;

   typedef struct {
      logic [1:0] sel;
      logic       tgt;
      logic       up;
      logic       dn;
      logic [4:0] h;
      logic [5:0] m;
   } edit_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t exp_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   alarm_clock_if bus ();

   alarm_clock #(.CLK_FREQ(10), .FRE(1), .DC(80), .RING_SECS(3)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] pk(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                      input logic [2:0] b, input logic r, input logic t);
      return {h, m, s, b, r, t};
   endfunction

   function automatic logic [21:0] observed();
      return {bus.o_hours, bus.o_mins, bus.o_secs, bus.o_blank, bus.o_ring, bus.o_tick_1hz};
   endfunction

   task automatic init_inputs();
      bus.i_run = 1'b0; bus.i_sel = 2'b00; bus.i_tgt = 1'b0; bus.i_plus = 1'b0;
      bus.i_minus = 1'b0; bus.i_alarm_en = 1'b0; bus.i_alarm_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      init_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic edit(input logic [1:0] sel, input logic tgt, input logic up, input logic dn);
      bus.i_sel = sel; bus.i_tgt = tgt; bus.i_plus = up; bus.i_minus = dn;
      @(negedge clk);
      bus.i_sel = 2'b00; bus.i_plus = 1'b0; bus.i_minus = 1'b0;
   endtask

   // Reset, set alarm 00:01, arm and count until one cycle before the match.
   task automatic arm_and_run();
      do_reset();
      edit(2'b10, 1'b1, 1'b1, 1'b0);
      bus.i_tgt = 1'b0; bus.i_alarm_en = 1'b1; bus.i_run = 1'b1;
      repeat (599) @(negedge clk);
      exp_q.push_back('{tag: "pre_match", val: pk(5'd0, 6'd0, 6'd59, 3'd0, 1'b0, 1'b0), mask: M_TIME | M_RING});
      e = exp_q.pop_front();
      n_cmp++;
      if ((observed() & e.mask) !== (e.val & e.mask)) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
      end
      exp_q.push_back('{tag: "match_ring", val: pk(5'd0, 6'd1, 6'd0, 3'd0, 1'b1, 1'b1), mask: M_ALL});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((observed() & e.mask) !== (e.val & e.mask)) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
      end
   endtask

   task automatic test_reset();
      bus.i_run = 1'b1; bus.i_sel = 2'b11; bus.i_plus = 1'b1;
      do_reset();
      exp_q.push_back('{tag: "reset_state", val: pk(5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0), mask: M_ALL});
      e = exp_q.pop_front();
      n_cmp++;
      if ((observed() & e.mask) !== (e.val & e.mask)) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
      end
   endtask

   task automatic test_count();
      do_reset();
      bus.i_run = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         exp_q.push_back('{tag: $sformatf("count_c%0d", k),
                           val: pk(5'd0, 6'd0, (k >= 10) ? 6'd1 : 6'd0, 3'd0, 1'b0, (k == 10)),
                           mask: M_TIME | M_TICK});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
      repeat (588) @(negedge clk);
      exp_q.push_back('{tag: "count_599", val: pk(5'd0, 6'd0, 6'd59, 3'd0, 1'b0, 1'b0), mask: M_TIME | M_TICK});
      exp_q.push_back('{tag: "count_600", val: pk(5'd0, 6'd1, 6'd0, 3'd0, 1'b0, 1'b1), mask: M_TIME | M_TICK});
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_carry();
      logic [21:0] want [3];
      logic [1:0]  fsel [3];
      want = '{pk(5'd0, 6'd0, 6'd59, 3'd0, 1'b0, 1'b0), pk(5'd0, 6'd59, 6'd59, 3'd0, 1'b0, 1'b0),
               pk(5'd23, 6'd59, 6'd59, 3'd0, 1'b0, 1'b0)};
      fsel = '{2'b01, 2'b10, 2'b11};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{tag: $sformatf("carry_edit%0d", i), val: want[i], mask: M_TIME});
         edit(fsel[i], 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
      bus.i_run = 1'b1;
      exp_q.push_back('{tag: "carry_pre", val: pk(5'd23, 6'd59, 6'd59, 3'd0, 1'b0, 1'b0), mask: M_TIME | M_TICK});
      exp_q.push_back('{tag: "carry_wrap", val: pk(5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b1), mask: M_TIME | M_TICK});
      repeat (9) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_edit();
      edit_t tab [9];
      tab = '{'{2'b10, 1'b0, 1'b0, 1'b1, 5'd0, 6'd59}, '{2'b10, 1'b0, 1'b1, 1'b1, 5'd0, 6'd59},
              '{2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 6'd59}, '{2'b11, 1'b1, 1'b1, 1'b0, 5'd1, 6'd0},
              '{2'b01, 1'b1, 1'b1, 1'b0, 5'd1, 6'd0},  '{2'b10, 1'b1, 1'b0, 1'b1, 5'd1, 6'd59},
              '{2'b00, 1'b1, 1'b0, 1'b1, 5'd1, 6'd59}, '{2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0},
              '{2'b11, 1'b0, 1'b0, 1'b1, 5'd23, 6'd0}};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back('{tag: $sformatf("edit_%0d", i), val: pk(tab[i].h, tab[i].m, 6'd0, 3'd0, 1'b0, 1'b0),
                           mask: M_TIME});
         edit(tab[i].sel, tab[i].tgt, tab[i].up, tab[i].dn);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
   endtask

   task automatic test_blank_edit();
      logic [1:0] fsel [2];
      logic [2:0] fmask [2];
      fsel  = '{2'b11, 2'b01};
      fmask = '{3'b100, 3'b001};
      do_reset();
      for (int f = 0; f < 2; f++) begin
         bus.i_sel = fsel[f];
         for (int k = 1; k <= 21; k++) begin
            exp_q.push_back('{tag: $sformatf("blank_s%0d_c%0d", fsel[f], k),
                              val: pk(5'd0, 6'd0, 6'd0, (((k - 1) % 10) >= 8) ? fmask[f] : 3'b000, 1'b0, 1'b0),
                              mask: M_BLANK});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ((observed() & e.mask) !== (e.val & e.mask)) begin
               n_bad++;
               $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
            end
         end
         bus.i_sel = 2'b00;
         exp_q.push_back('{tag: "blank_release", val: pk(5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0), mask: M_BLANK});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
   endtask

   task automatic test_ring_timeout();
      arm_and_run();
      for (int k = 1; k <= 30; k++) begin
         exp_q.push_back('{tag: $sformatf("ring_c%0d", k),
                           val: pk(5'd0, 6'd0, 6'd0, ((k < 30) && (((k - 1) % 10) >= 8)) ? 3'b111 : 3'b000,
                                   (k < 30), 1'b0),
                           mask: M_BLANK | M_RING});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
   endtask

   task automatic test_ring_cancel(input logic by_ack);
      arm_and_run();
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) begin
            if (by_ack) bus.i_alarm_ack = 1'b1;
            else        bus.i_alarm_en = 1'b0;
         end
         exp_q.push_back('{tag: $sformatf("cancel_ack%0d_c%0d", by_ack, k),
                           val: pk(5'd0, 6'd0, 6'd0, 3'd0, (k < 4), 1'b0), mask: M_BLANK | M_RING});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ((observed() & e.mask) !== (e.val & e.mask)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
         end
      end
      bus.i_alarm_ack = 1'b0;
   endtask

   task automatic test_reset_mid_ring();
      arm_and_run();
      repeat (8) @(negedge clk);
      bus.i_sel = 2'b11; bus.i_plus = 1'b1; reset = 1'b1;
      exp_q.push_back('{tag: "reset_mid_ring", val: pk(5'd0, 6'd0, 6'd0, 3'd0, 1'b0, 1'b0), mask: M_ALL});
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ((observed() & e.mask) !== (e.val & e.mask)) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", e.tag, observed() & e.mask, e.val & e.mask);
      end
      reset = 1'b0;
      init_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      init_inputs();
      test_reset();
      test_count();
      test_carry();
      test_edit();
      test_blank_edit();
      test_ring_timeout();
      test_ring_cancel(1'b1);
      test_ring_cancel(1'b0);
      test_reset_mid_ring();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alarm_clock.md
ALARM_CLOCK -- requirements
Module: alarm_clock

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clock cycles per second.
REQ-002 SHALL have parameter FRE, default 2, edit/ring flash frequency in Hz.
REQ-003 SHALL have parameter DC, default 80, flash visible duty cycle in percent (1..99).
REQ-004 SHALL have parameter RING_SECS, default 60, ring auto-timeout in seconds.
REQ-005 SHALL have ports: clk  in  1  system clock, single clock domain, all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port run  in  1  time counting enable.
REQ-008 SHALL have port sel  in  2  edit field select: 00 none, 01 secs, 10 mins, 11 hours.
REQ-009 SHALL have port tgt  in  1  edit/display target: 0 time, 1 alarm.
REQ-010 SHALL have ports plus, minus  in  1 each  one-cycle edit pulses.
REQ-011 SHALL have port alarm_en  in  1  alarm arm.
REQ-012 SHALL have port alarm_ack  in  1  ring acknowledge.
REQ-013 SHALL have outputs hours  out  5, mins  out  6, secs  out  6  displayed value: time if tgt=0, else alarm with secs=0.
REQ-014 SHALL have outputs blank  out  3  per-field blank mask {hours,mins,secs}; ring  out  1  alarm ringing; tick_1hz  out  1  one-cycle seconds strobe.

Function
REQ-015 Prescaler SHALL count 0..CLK_FREQ-1 when run=1 and sel=00, else hold; tick when at CLK_FREQ-1, then wrap to 0.
REQ-016 On tick, secs SHALL increment; 59->0 carries into mins; mins 59->0 carries into hours; hours 23->0; tick_1hz=1 that cycle only (registered, visible next cycle with new time).
REQ-017 With sel!=00, plus SHALL increment and minus decrement the selected field of tgt, one cycle latency, modulo field range (secs/mins 0..59, hours 0..23), no carry/borrow into other fields.
REQ-018 plus and minus asserted together SHALL cause no change; edits with sel=00 SHALL be ignored.
REQ-019 Alarm holds hours and mins only; sel=01 with tgt=1 edits SHALL be ignored.
REQ-020 Any applied edit to time SHALL clear the prescaler to 0.
REQ-021 Ring state machine SHALL have states IDLE and RINGING; ring=1 exactly in RINGING.
REQ-022 IDLE->RINGING SHALL occur on the edge where a tick makes time equal alarm hours:mins with secs=0 and alarm_en=1; edits landing on the match SHALL NOT trigger.
REQ-023 RINGING->IDLE SHALL occur on alarm_ack=1, alarm_en=0, or after RING_SECS ticks in RINGING; ack SHALL win over a simultaneous new match.
REQ-024 Flash counter SHALL run with period CLK_FREQ/FRE cycles while sel!=00 or RINGING, else held at 0; phase visible for first (period*DC)/100 cycles, blanked for remainder.
REQ-025 blank SHALL equal selected-field bit during blanked phase when sel!=00 (sel has priority); 3'b111 during blanked phase when RINGING and sel=00; 3'b000 otherwise, within one cycle of conditions clearing.
REQ-026 Time SHALL keep counting while RINGING.

Reset
REQ-027 On reset=1 at a clock edge, time SHALL become 00:00:00, alarm 00:00, prescaler and flash counter 0, state IDLE, ring=0, blank=000, tick_1hz=0, overriding all other inputs including mid-ring and mid-edit.

Verification (CLK_FREQ=10, FRE=1, DC=80, RING_SECS=3)
REQ-028 Reset, run=1, sel=00, 10 cycles -> secs=1, single-cycle tick_1hz; 600 cycles -> 00:01:00.
REQ-029 Edit time to 23:59:59 via minus from 0 on each field, run 10 cycles -> 00:00:00, all carries in one edge.
REQ-030 sel=10, tgt=0, mins=0, minus -> mins=59, hours unchanged; plus+minus same cycle -> no change; tgt=1 sel=01 plus -> alarm unchanged.
REQ-031 Alarm 00:01, alarm_en=1, run from 00:00:00 -> ring=1 same cycle time shows 00:01:00; no ack -> ring=0 after 30 cycles; repeat with ack -> ring=0 next cycle.
REQ-032 sel=11 -> blank[2] pattern 8 cycles 0, 2 cycles 1, repeating; sel->00 -> blank=000 next cycle; during ring blank alternates 000/111.
REQ-033 reset asserted while RINGING and editing -> all outputs at reset values after that edge.
